// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetch unit: issues sequential word fetches, buffers in-order
// responses in a small FIFO and hands {instr, pc} to decode. A redirect
// flushes the buffer and discards responses still owed by memory.
module fetch_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OUT_W-1:0] inflight_q, inflight_d;
  logic [OUT_W-1:0] discard_q, discard_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  logic [31:0]      instr_mem [DEPTH];
  logic [31:0]      pc_mem    [DEPTH];

  logic             rsp_live;
  logic             req_fire;
  logic             push;
  logic             pop;

  // Head of the FIFO; outputs read as zero whenever the FIFO is empty.
  assign out_valid     = (count_q != '0);
  assign out_instr     = out_valid ? instr_mem[rd_ptr_q] : 32'h0;
  assign out_pc        = out_valid ? pc_mem[rd_ptr_q] : 32'h0;
  assign imem_req_addr = fetch_pc_q;

  // Request only when every outstanding word already has a FIFO slot reserved.
  always_comb begin
    imem_req_valid = reset
                  && (state_q == ST_FETCH)
                  && !redirect_valid
                  && ((32'(count_q) + 32'(inflight_q)) < DEPTH)
                  && (32'(inflight_q) < MAX_OUT);
  end

  // Handshake qualifiers; a response with nothing outstanding is ignored.
  always_comb begin
    rsp_live = imem_rsp_valid && (inflight_q != '0);
    req_fire = imem_req_valid && imem_req_ready;
    push     = rsp_live && !redirect_valid && (discard_q == '0);
    pop      = out_valid && out_ready && !redirect_valid;
  end

  // Next-state logic; redirect overrides every other update.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      inflight_d = inflight_q - OUT_W'(rsp_live);
      discard_d  = inflight_q - OUT_W'(rsp_live);
      state_d    = (discard_d != '0) ? ST_DRAIN : ST_FETCH;
    end else begin
      if (req_fire && !rsp_live) begin
        inflight_d = inflight_q + OUT_W'(1);
      end else if (rsp_live && !req_fire) begin
        inflight_d = inflight_q - OUT_W'(1);
      end

      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end

      if (rsp_live && (discard_q != '0)) begin
        discard_d = discard_q - OUT_W'(1);
      end

      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        rsp_pc_d = rsp_pc_q + 32'd4;
      end

      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end

      if ((state_q == ST_DRAIN) && (discard_d == '0)) begin
        state_d = ST_FETCH;
      end
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are only observed through a nonzero count.
  always_ff @(posedge clock) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_rsp_data;
      pc_mem[wr_ptr_q]    <= rsp_pc_q;
    end
  end

endmodule

// File: doc/fetch_prefetch_unit.md
FETCH_PREFETCH_UNIT -- requirements
Module: fetch_prefetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning instruction FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter MAX_OUT, default 2, meaning the maximum number of outstanding memory requests.
REQ-003 SHALL have parameter RESET_PC, default 32'h0, meaning the first fetch address after reset.
REQ-004 SHALL have one clock and an asynchronous active-low reset; port list follows.
REQ-005 clock  in  1  sole clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 redirect_valid  in  1  flush the unit and restart fetch at redirect_pc.
REQ-008 redirect_pc  in  32  new fetch address, word aligned.
REQ-009 imem_req_valid  out  1  fetch request valid.
REQ-010 imem_req_ready  in  1  memory accepts request.
REQ-011 imem_req_addr  out  32  byte address of the requested word.
REQ-012 imem_rsp_valid  in  1  one-cycle pulse carrying an in-order response.
REQ-013 imem_rsp_data  in  32  instruction word.
REQ-014 out_valid  out  1  instruction available to the decode stage.
REQ-015 out_ready  in  1  decode stage accepts the instruction.
REQ-016 out_instr  out  32  head instruction.
REQ-017 out_pc  out  32  byte address of out_instr.

Function
REQ-018 SHALL hold state: fetch_pc, rsp_pc, a FIFO of {instr,pc}, count (0..DEPTH), inflight (0..MAX_OUT), discard (0..MAX_OUT), and a 2-state FSM {FETCH, DRAIN}.
REQ-019 SHALL drive imem_req_valid = (state==FETCH) && !redirect_valid && (count+inflight < DEPTH) && (inflight < MAX_OUT), combinationally; imem_req_addr = fetch_pc.
REQ-020 SHALL treat req_valid && req_ready as acceptance: fetch_pc += 4 (modulo 2^32, 32'hFFFFFFFC wraps to 0) and inflight += 1.
REQ-021 SHALL decrement inflight on every imem_rsp_valid; inflight increments and decrements in the same cycle SHALL net to zero.
REQ-022 SHALL drop a response when discard>0 (discard -= 1); otherwise SHALL push {imem_rsp_data, rsp_pc} and set rsp_pc += 4.
REQ-023 SHALL drive out_valid = (count != 0), with out_instr and out_pc taken from the FIFO head; pop on out_valid && out_ready.
REQ-024 SHALL support push and pop in the same cycle, including when count==DEPTH is not reached; by REQ-019 the FIFO SHALL never overflow.
REQ-025 Latency: a non-discarded response at edge N SHALL appear on out_valid after edge N (one-cycle registered).
REQ-026 Redirect (highest priority) SHALL, at the clock edge: empty the FIFO (count=0, pointers=0), ignore any pop that cycle, drop any response that cycle, set fetch_pc=rsp_pc=redirect_pc, and set discard = inflight - imem_rsp_valid.
REQ-027 After a redirect, state SHALL go to DRAIN if the new discard>0, else FETCH.
REQ-028 In DRAIN, the unit SHALL issue no requests; it SHALL enter FETCH on the edge where discard reaches 0.
REQ-029 A redirect while in DRAIN SHALL recompute discard per REQ-026; it SHALL not stack with the old value.
REQ-030 An imem_rsp_valid with inflight==0 is a protocol violation; it SHALL be ignored with no state change.
REQ-031 If out_ready is held low, the FIFO SHALL fill to DEPTH and requests SHALL stop; no data SHALL be lost.

Reset
REQ-032 While reset==0: fetch_pc=rsp_pc=RESET_PC, count=inflight=discard=0, state=FETCH, out_valid=0, imem_req_valid=0, out_instr=out_pc=0.
REQ-033 Reset mid-operation SHALL abandon all in-flight requests; the memory model SHALL be reset with the unit.
REQ-034 The first request SHALL be issued in the first cycle after reset deasserts, with addr=RESET_PC.

Verification
REQ-035 Streaming, 1-cycle memory, out_ready=1 -> out_pc sequence 0,4,8,12, each with the matching word; no gaps after the pipeline fills.
REQ-036 Backpressure, out_ready=0 for 20 cycles -> count=4, imem_req_valid=0, no drops; after release, pcs stay contiguous.
REQ-037 Redirect to 0x40 with 2 requests in flight -> both stale responses dropped, DRAIN for 2 responses, the next out_pc is 0x40.
REQ-038 Redirect coincident with a response and a pop -> FIFO empty next cycle, discard=inflight-1, no stale pc ever appears on the output.
REQ-039 Redirect to 0xFFFFFFF8 -> out_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
REQ-040 Reset asserted mid-stream with random memory latency 1-5 -> outputs zero immediately; after release, out_pc starts at RESET_PC.
